// File: rtl/maxpool2x2_stream.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream
//
// Streaming 2x2 / stride-2 max-pool. Pixels arrive one per accepted beat in
// row-major order from an H_IN x W_IN map. The pooled (H_IN/2 x W_IN/2) map
// leaves on a valid/ready stream through a single-entry output register.
//
// Storage: one horizontal-hold register (left pixel of the current pair), a
// line buffer of W_IN/2 horizontal maxima from the even row, and the output
// register. A pooled pixel appears the cycle after its bottom-right input
// pixel is accepted.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits
//   FLOAT_MODE  0 = two's-complement compare, 1 = IEEE-754 single compare
//   H_IN, W_IN  input map size (both even, >= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in_valid    in_data holds a valid pixel
//   in_ready    block accepts in_data this cycle
//   in_data     conv-result pixel, row-major
//   out_valid   out_data holds a valid pooled pixel
//   out_ready   downstream accepts out_data this cycle
//   out_data    pooled maximum
//   out_last    marks the final pooled pixel of the frame
//   frame_done  one-cycle pulse after the frame's last input pixel is accepted
//
// Build option:
//   MAXPOOL_RELU_EN  when defined, each accepted pixel with its sign bit set
//                    (including -0.0) is replaced by zero before pooling.
// ---------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int FLOAT_MODE = 1,
    parameter int H_IN       = 28,
    parameter int W_IN       = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done
);

    localparam int HALF_W = W_IN / 2;
    localparam int CW     = (W_IN > 2) ? $clog2(W_IN) : 1;
    localparam int RW     = (H_IN > 2) ? $clog2(H_IN) : 1;
    localparam int LBW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    // Returns b only when b is strictly greater, so ties keep the earlier
    // operand a.
    function automatic logic [DATA_WIDTH-1:0] pick_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic                  b_wins;
        logic [DATA_WIDTH-2:0] mag_a;
        logic [DATA_WIDTH-2:0] mag_b;
        mag_a = a[DATA_WIDTH-2:0];
        mag_b = b[DATA_WIDTH-2:0];
        if (FLOAT_MODE != 0) begin
            // Sign-magnitude ordering; +0 and -0 are equal.
            case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
                2'b00:   b_wins = (mag_b > mag_a);
                2'b11:   b_wins = (mag_b < mag_a);
                2'b10:   b_wins = (mag_a != '0) || (mag_b != '0);
                default: b_wins = 1'b0;
            endcase
        end else begin
            b_wins = ($signed(b) > $signed(a));
        end
        return b_wins ? b : a;
    endfunction

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] linebuf [HALF_W];

    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic [LBW-1:0]        lb_idx;
    logic [DATA_WIDTH-1:0] pix;
    logic [DATA_WIDTH-1:0] hmax;
    logic [DATA_WIDTH-1:0] vmax;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col == CW'(W_IN - 1));
    assign row_last = (row == RW'(H_IN - 1));
    assign lb_idx   = LBW'(col >> 1);

`ifdef MAXPOOL_RELU_EN
    assign pix = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign pix = in_data;
`endif

    assign hmax = pick_max(hold, pix);
    assign vmax = pick_max(linebuf[lb_idx], hmax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && row_last && col_last;

            // Drain first; a load in the same cycle overrides below.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    hold <= pix;
                end else if (row[0]) begin
                    out_valid <= 1'b1;
                    out_data  <= vmax;
                    out_last  <= row_last && col_last;
                end
            end
        end
    end

    // Line buffer carries no reset: every entry is rewritten on the even row
    // before the odd row reads it.
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0])
            linebuf[lb_idx] <= hmax;
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // 4x4 signed-integer instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        frame_done;

    // 2x2 float instance
    logic        f_in_valid;
    logic        f_in_ready;
    logic [31:0] f_in_data;
    logic        f_out_valid;
    logic        f_out_ready;
    logic [31:0] f_out_data;
    logic        f_out_last;
    logic        f_frame_done;

    maxpool2x2_stream #(
        .DATA_WIDTH(32), .FLOAT_MODE(0), .H_IN(4), .W_IN(4)
    ) u_int (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .frame_done(frame_done)
    );

    maxpool2x2_stream #(
        .DATA_WIDTH(32), .FLOAT_MODE(1), .H_IN(2), .W_IN(2)
    ) u_flt (
        .clk(clk), .rst(rst),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
        .out_last(f_out_last), .frame_done(f_frame_done)
    );

    logic [32:0] exp_q[$];
    logic [32:0] fexp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fd_count = 0;
    logic        acc = 1'b0;
    logic        facc = 1'b0;
    logic        rand_rdy = 1'b0;

`ifdef MAXPOOL_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        acc  = in_valid && in_ready;
        facc = f_in_valid && f_in_ready;
        if (frame_done) fd_count++;
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL int_extra_out observed=%h expected=none", out_data);
            end
            if (exp_q.size() != 0) chk("int_out", {out_last, out_data}, exp_q.pop_front());
        end
        if (f_out_valid && f_out_ready) begin
            checks++;
            assert (fexp_q.size() != 0) else begin
                errors++;
                $error("FAIL flt_extra_out observed=%h expected=none", f_out_data);
            end
            if (fexp_q.size() != 0) chk("flt_out", {f_out_last, f_out_data}, fexp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            tick();
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL int_send_timeout observed=%0d expected=accept", n);
        end
    endtask

    task automatic fsend(input logic [31:0] d);
        int n = 0;
        f_in_valid = 1'b1;
        f_in_data  = d;
        do begin
            tick();
            n++;
        end while (!facc && n < 100);
        f_in_valid = 1'b0;
        checks++;
        assert (facc) else begin
            errors++;
            $error("FAIL flt_send_timeout observed=%0d expected=accept", n);
        end
    endtask

    task automatic push_std_frame();
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b0, 32'd7});
        exp_q.push_back({1'b0, 32'd13});
        exp_q.push_back({1'b1, 32'd15});
    endtask

    logic [31:0] sframe [16];
    logic [31:0] fpix   [16];

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        f_in_valid = 1'b0; f_in_data = '0; f_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", 33'(out_valid), 33'd0);
        chk("rst_out_data", 33'(out_data), 33'd0);
        chk("rst_out_last", 33'(out_last), 33'd0);
        chk("rst_frame_done", 33'(frame_done), 33'd0);
        chk("rst_in_ready", 33'(in_ready), 33'd1);
        rst = 1'b1;
        tick();

        // Basic 4x4 frame 0..15, no backpressure
        fd_count = 0;
        push_std_frame();
        for (int i = 0; i < 16; i++) send(32'(i));
        chk("t1_frame_done_pulse", 33'(frame_done), 33'd1);
        tick();
        chk("t1_frame_done_low", 33'(frame_done), 33'd0);
        tick();
        chk("t1_fd_count", 33'(fd_count), 33'd1);
        chk("t1_queue_empty", 33'(exp_q.size()), 33'd0);

        // Output stall from the first pooled pixel
        out_ready = 1'b0;
        push_std_frame();
        for (int i = 0; i < 6; i++) send(32'(i));
        in_valid = 1'b1;
        in_data  = 32'd6;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2_stall_valid", 33'(out_valid), 33'd1);
            chk("t2_stall_data", 33'(out_data), 33'd5);
            chk("t2_stall_in_ready", 33'(in_ready), 33'd0);
            chk("t2_stall_no_accept", 33'(acc), 33'd0);
        end
        out_ready = 1'b1;
        for (int i = 6; i < 16; i++) send(32'(i));
        repeat (2) tick();
        chk("t2_queue_empty", 33'(exp_q.size()), 33'd0);

        // Signed ties, negatives and extremes
        sframe = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000,
                   32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'd0,         32'd1,
                   32'd3,         32'd2,         32'd10,        32'd20,
                   32'd1,         32'd4,         32'd30,        32'd25};
        exp_q.push_back({1'b0, RELU ? 32'd0 : 32'hFFFF_FFFB});
        exp_q.push_back({1'b0, 32'h7FFF_FFFF});
        exp_q.push_back({1'b0, 32'd4});
        exp_q.push_back({1'b1, 32'd30});
        for (int i = 0; i < 16; i++) send(sframe[i]);
        repeat (2) tick();
        chk("t3_queue_empty", 33'(exp_q.size()), 33'd0);

        // Reset in the middle of a frame
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'(100 + i));
        rst = 1'b0;
        #2;
        chk("t4_rst_out_valid", 33'(out_valid), 33'd0);
        tick();
        chk("t4_rst_out_data", 33'(out_data), 33'd0);
        chk("t4_rst_in_ready", 33'(in_ready), 33'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        push_std_frame();
        for (int i = 0; i < 16; i++) send(32'(i));
        repeat (2) tick();
        chk("t4_queue_empty", 33'(exp_q.size()), 33'd0);

        // Two back-to-back frames, random gaps and backpressure
        fd_count = 0;
        push_std_frame();
        push_std_frame();
        rand_rdy = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(32'(i));
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
        tick();
        chk("t5_queue_empty", 33'(exp_q.size()), 33'd0);
        chk("t5_fd_count", 33'(fd_count), 33'd2);
        chk("t5_out_valid_idle", 33'(out_valid), 33'd0);

        // Float instance, one 2x2 window per frame
        fpix = '{32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 32'hC040_0000,
                 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
                 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hC080_0000,
                 32'hC0A0_0000, 32'h3F00_0000, 32'h0000_0000, 32'hBF80_0000};
        fexp_q.push_back({1'b1, RELU ? 32'h0 : 32'hBF00_0000});
        fexp_q.push_back({1'b1, RELU ? 32'h0 : 32'h8000_0000});
        fexp_q.push_back({1'b1, 32'h4000_0000});
        fexp_q.push_back({1'b1, 32'h3F00_0000});
        for (int i = 0; i < 16; i++) fsend(fpix[i]);
        repeat (2) tick();
        chk("t6_flt_queue_empty", 33'(fexp_q.size()), 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
